// File: rtl/step_ctrl_pkg.sv
// Shared definitions for the stepper axis: controller state encoding and the
// field widths of the pulse-generator and step-count interfaces.
package step_ctrl_pkg;

  localparam int PERIOD_W    = 16;
  localparam int PG_PERIOD_W = 32;
  localparam int STEP_CNT_W  = 32;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ACCEL,
    ST_CRUISE,
    ST_DECEL,
    ST_FINISH
  } ctrl_state_e;

endpackage

// File: rtl/ramp_period_calc.sv
// Saturating period step for the ramp: adds or subtracts delta and clamps the
// result into [min_period, max_period] using one guard bit.
module ramp_period_calc
  import step_ctrl_pkg::*;
(
  input  logic [PERIOD_W-1:0] period,
  input  logic                ramp_up,
  input  logic [PERIOD_W-1:0] delta,
  input  logic [PERIOD_W-1:0] min_period,
  input  logic [PERIOD_W-1:0] max_period,
  output logic [PERIOD_W-1:0] next_period
);

  logic [PERIOD_W:0] sum;
  logic [PERIOD_W:0] diff;

  // The guard bit catches both add overflow and subtract borrow.
  always_comb begin
    sum         = {1'b0, period} + {1'b0, delta};
    diff        = {1'b0, period} - {1'b0, delta};
    next_period = period;
    if (ramp_up) begin
      if (sum > {1'b0, max_period}) next_period = max_period;
      else                          next_period = sum[PERIOD_W-1:0];
    end else begin
      if (diff[PERIOD_W] || (diff < {1'b0, min_period})) next_period = min_period;
      else                                               next_period = diff[PERIOD_W-1:0];
    end
  end

endmodule

// File: rtl/step_ramp_ctrl.sv
// Per-axis motion sequencer: accepts a move command and feeds the step-pulse
// generator a trapezoidal period profile, one period update per completed step.
module step_ramp_ctrl
  import step_ctrl_pkg::*;
#(
  parameter int START_PERIOD = 2000,
  parameter int MIN_PERIOD   = 200,
  parameter int ACC_DELTA    = 10
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [STEP_CNT_W-1:0]  cmd_steps,
  input  logic                   cmd_dir,
  input  logic                   abort,
  output logic                   pg_start,
  output logic [PG_PERIOD_W-1:0] pg_period,
  input  logic                   pg_done,
  output logic                   dir_out,
  output logic                   busy,
  output logic [STEP_CNT_W-1:0]  steps_done,
  output logic                   done,
  output logic                   aborted
);

  localparam logic [PERIOD_W-1:0] START_P = PERIOD_W'(START_PERIOD);
  localparam logic [PERIOD_W-1:0] MIN_P   = PERIOD_W'(MIN_PERIOD);
  localparam logic [PERIOD_W-1:0] DELTA_P = PERIOD_W'(ACC_DELTA);

  ctrl_state_e           state_q, state_d;
  logic [PERIOD_W-1:0]   period_q, period_d;
  logic [STEP_CNT_W-1:0] remaining_q, remaining_d;
  logic [STEP_CNT_W-1:0] accel_cnt_q, accel_cnt_d;
  logic [STEP_CNT_W-1:0] steps_done_q, steps_done_d;
  logic [STEP_CNT_W-1:0] rem_dec;
  logic                  pg_start_q, pg_start_d;
  logic                  dir_q, dir_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  aborted_q, aborted_d;
  logic                  cmd_ready_q, cmd_ready_d;
  logic [PERIOD_W-1:0]   up_period;
  logic [PERIOD_W-1:0]   down_period;

  ramp_period_calc u_ramp_up (
    .period      (period_q),
    .ramp_up     (1'b1),
    .delta       (DELTA_P),
    .min_period  (MIN_P),
    .max_period  (START_P),
    .next_period (up_period)
  );

  ramp_period_calc u_ramp_down (
    .period      (period_q),
    .ramp_up     (1'b0),
    .delta       (DELTA_P),
    .min_period  (MIN_P),
    .max_period  (START_P),
    .next_period (down_period)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      period_q     <= START_P;
      remaining_q  <= '0;
      accel_cnt_q  <= '0;
      steps_done_q <= '0;
      pg_start_q   <= 1'b0;
      dir_q        <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      aborted_q    <= 1'b0;
      cmd_ready_q  <= 1'b1;
    end else begin
      state_q      <= state_d;
      period_q     <= period_d;
      remaining_q  <= remaining_d;
      accel_cnt_q  <= accel_cnt_d;
      steps_done_q <= steps_done_d;
      pg_start_q   <= pg_start_d;
      dir_q        <= dir_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      aborted_q    <= aborted_d;
      cmd_ready_q  <= cmd_ready_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    period_d     = period_q;
    remaining_d  = remaining_q;
    accel_cnt_d  = accel_cnt_q;
    steps_done_d = steps_done_q;
    pg_start_d   = pg_start_q;
    dir_d        = dir_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    aborted_d    = aborted_q;
    cmd_ready_d  = cmd_ready_q;
    rem_dec      = remaining_q - STEP_CNT_W'(1);

    case (state_q)
      // cmd_ready comes back one cycle after the done pulse, so no accept overlaps done.
      ST_IDLE: begin
        if (!cmd_ready_q) begin
          cmd_ready_d = 1'b1;
        end else if (cmd_valid) begin
          cmd_ready_d  = 1'b0;
          dir_d        = cmd_dir;
          remaining_d  = cmd_steps;
          steps_done_d = '0;
          accel_cnt_d  = '0;
          aborted_d    = 1'b0;
          period_d     = START_P;
          busy_d       = 1'b1;
          if (cmd_steps == '0) begin
            state_d = ST_FINISH;
          end else begin
            state_d    = ST_ACCEL;
            pg_start_d = 1'b1;
          end
        end
      end

      ST_ACCEL, ST_CRUISE, ST_DECEL: begin
        if (pg_done) begin
          remaining_d  = rem_dec;
          steps_done_d = steps_done_q + STEP_CNT_W'(1);
          if (rem_dec == '0) begin
            state_d    = ST_FINISH;
            pg_start_d = 1'b0;
          end else if ((rem_dec <= accel_cnt_q) && (state_q != ST_DECEL)) begin
            state_d  = ST_DECEL;
            period_d = up_period;
          end else if (state_q == ST_ACCEL) begin
            // A flat profile (start == min) cruises at once without counting a ramp step.
            if (period_q == MIN_P) begin
              state_d = ST_CRUISE;
            end else begin
              period_d    = down_period;
              accel_cnt_d = accel_cnt_q + STEP_CNT_W'(1);
              if (down_period == MIN_P) state_d = ST_CRUISE;
            end
          end else if (state_q == ST_DECEL) begin
            period_d = up_period;
          end
        end
        if (abort) begin
          state_d    = ST_FINISH;
          pg_start_d = 1'b0;
          aborted_d  = 1'b1;
        end
      end

      ST_FINISH: begin
        pg_start_d = 1'b0;
        done_d     = 1'b1;
        busy_d     = 1'b0;
        state_d    = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  assign cmd_ready  = cmd_ready_q;
  assign pg_start   = pg_start_q;
  assign pg_period  = {{(PG_PERIOD_W-PERIOD_W){1'b0}}, period_q};
  assign dir_out    = dir_q;
  assign busy       = busy_q;
  assign steps_done = steps_done_q;
  assign done       = done_q;
  assign aborted    = aborted_q;

endmodule

// File: tb/tb_step_ramp_ctrl.sv
// Self-checking bench for step_ramp_ctrl: a pulse-generator model plus a
// trapezoid profile model compared against directed and random moves.
module tb_step_ramp_ctrl;

  localparam int START_P = 100;
  localparam int MIN_P   = 40;
  localparam int DELTA_P = 20;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [31:0] cmd_steps;
  logic        cmd_dir;
  logic        abort;
  logic        pg_start;
  logic [31:0] pg_period;
  logic        pg_done = 1'b0;
  logic        dir_out;
  logic        busy;
  logic [31:0] steps_done;
  logic        done;
  logic        aborted;

  int checks = 0;
  int errors = 0;

  int gen_cnt = 0;
  int gen_cur = 0;
  bit gen_gap = 0;
  int gen_q[$];
  int exp_q[$];

  always #5 clk = ~clk;

  step_ramp_ctrl #(
    .START_PERIOD (START_P),
    .MIN_PERIOD   (MIN_P),
    .ACC_DELTA    (DELTA_P)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_steps  (cmd_steps),
    .cmd_dir    (cmd_dir),
    .abort      (abort),
    .pg_start   (pg_start),
    .pg_period  (pg_period),
    .pg_done    (pg_done),
    .dir_out    (dir_out),
    .busy       (busy),
    .steps_done (steps_done),
    .done       (done),
    .aborted    (aborted)
  );

  // Generator model: loads the period at step start, pulses pg_done at the end,
  // then idles one cycle so the controller's updated period is picked up.
  always @(negedge clk) begin
    if (rst || !pg_start) begin
      gen_cnt = 0;
      gen_gap = 0;
      pg_done = 1'b0;
    end else begin
      pg_done = 1'b0;
      if (gen_gap) begin
        gen_gap = 0;
      end else if (gen_cnt == 0) begin
        gen_cnt = int'(pg_period);
        gen_cur = gen_cnt;
      end else begin
        gen_cnt--;
        if (gen_cnt == 0) begin
          pg_done = 1'b1;
          gen_q.push_back(gen_cur);
          gen_gap = 1;
        end
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Period of every step of an n-step move, straight from the ramp rules.
  function automatic void buildProfile(input int n);
    int p = START_P;
    int acc = 0;
    int rem = n;
    int phase = 0;
    exp_q.delete();
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(p);
      rem--;
      if (rem == 0) break;
      if (rem <= acc && phase != 2) begin
        phase = 2;
        p = (p + DELTA_P > START_P) ? START_P : p + DELTA_P;
      end else if (phase == 0) begin
        if (p == MIN_P) begin
          phase = 1;
        end else begin
          p = (p - DELTA_P < MIN_P) ? MIN_P : p - DELTA_P;
          acc++;
          if (p == MIN_P) phase = 1;
        end
      end else if (phase == 2) begin
        p = (p + DELTA_P > START_P) ? START_P : p + DELTA_P;
      end
    end
  endfunction

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_pg_start"}, pg_start, 0);
    checkOutput({tag, "_pg_period"}, pg_period, START_P);
    checkOutput({tag, "_cmd_ready"}, cmd_ready, 1);
    checkOutput({tag, "_dir_out"}, dir_out, 0);
    checkOutput({tag, "_busy"}, busy, 0);
    checkOutput({tag, "_steps_done"}, steps_done, 0);
    checkOutput({tag, "_done"}, done, 0);
    checkOutput({tag, "_aborted"}, aborted, 0);
  endtask

  task automatic applyStimulus(input int steps, input bit dir, input bit keep_valid, output int base);
    int waited = 0;
    @(negedge clk); #1;
    while (!cmd_ready && waited < 50) begin
      @(negedge clk); #1;
      waited++;
    end
    checkOutput("ready_before_cmd", cmd_ready, 1);
    base      = gen_q.size();
    cmd_valid = 1'b1;
    cmd_steps = steps;
    cmd_dir   = dir;
    @(posedge clk); #1;
    checkOutput("accept_busy", busy, 1);
    checkOutput("accept_cmd_ready", cmd_ready, 0);
    checkOutput("accept_dir_out", dir_out, dir);
    checkOutput("accept_steps_done", steps_done, 0);
    checkOutput("accept_aborted", aborted, 0);
    checkOutput("accept_pg_period", pg_period, START_P);
    checkOutput("accept_pg_start", pg_start, (steps != 0) ? 1 : 0);
    if (!keep_valid) cmd_valid = 1'b0;
  endtask

  // abort_mode: 0 none, 1 abort the cycle after the k-th pg_done, 2 with the k-th pg_done.
  task automatic runMove(input int n, input bit dir, input int abort_mode, input int k, input int base);
    int cyc = 0;
    int dones = 0;
    int done_cyc = -1;
    int exp_sd;
    int got;
    bit exp_ab;
    bit pend = 0;
    bit ab_live = 0;
    bit fired = 0;
    bit chk_fall = 0;
    bit ready_bad = 0;
    bit dir_bad = 0;
    bit ps_seen = 0;
    buildProfile(n);
    exp_ab = (abort_mode != 0);
    exp_sd = exp_ab ? k : n;
    while (dones == 0 && cyc < 20000) begin
      @(negedge clk); #1;
      cyc++;
      if (chk_fall) begin
        checkOutput("pg_start_low_after_last", pg_start, 0);
        chk_fall = 0;
      end
      if (ab_live) begin
        abort   = 1'b0;
        ab_live = 0;
        checkOutput("abort_pg_start_low", pg_start, 0);
      end
      if (pend) begin
        abort   = 1'b1;
        ab_live = 1;
        pend    = 0;
      end
      if (abort_mode != 0 && !fired && pg_done && (gen_q.size() - base) == k) begin
        fired = 1;
        if (abort_mode == 2) begin
          abort   = 1'b1;
          ab_live = 1;
        end else begin
          pend = 1;
        end
      end
      if (abort_mode == 0 && pg_done && (gen_q.size() - base) == n) chk_fall = 1;
      if (busy && cmd_ready) ready_bad = 1;
      if (dir_out !== dir) dir_bad = 1;
      if (pg_start) ps_seen = 1;
      if (done) begin
        dones++;
        done_cyc = cyc;
        checkOutput("done_pg_start", pg_start, 0);
        checkOutput("done_busy", busy, 0);
        checkOutput("done_steps_done", steps_done, exp_sd);
        checkOutput("done_aborted", aborted, exp_ab);
      end
    end
    checkOutput("move_done_seen", dones, 1);
    if (n == 0) begin
      checkOutput("zero_done_latency", done_cyc, 2);
      checkOutput("zero_no_pg_start", ps_seen, 0);
    end
    @(negedge clk); #1;
    checkOutput("done_single_cycle", done, 0);
    checkOutput("ready_after_done", cmd_ready, 1);
    checkOutput("ready_low_while_busy", ready_bad, 0);
    checkOutput("dir_stable", dir_bad, 0);
    got = gen_q.size() - base;
    checkOutput("period_count", got, exp_sd);
    for (int i = 0; i < exp_sd && i < got; i++)
      checkOutput($sformatf("period_step%0d", i + 1), gen_q[base + i], exp_q[i]);
  endtask

  initial begin
    int base;
    int n;
    int mode;
    int k;
    int waited;
    bit dir;
    bit stray_done;

    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_steps = '0;
    cmd_dir   = 1'b0;
    abort     = 1'b0;
    #12;
    checkResetValues("reset");
    @(negedge clk);
    rst = 1'b0;

    $display("[TB] trapezoid and triangle moves");
    applyStimulus(10, 1'b1, 1'b0, base);
    runMove(10, 1'b1, 0, 0, base);
    applyStimulus(4, 1'b0, 1'b0, base);
    runMove(4, 1'b0, 0, 0, base);

    $display("[TB] zero and one step moves");
    applyStimulus(0, 1'b1, 1'b0, base);
    runMove(0, 1'b1, 0, 0, base);
    applyStimulus(1, 1'b0, 1'b0, base);
    runMove(1, 1'b0, 0, 0, base);

    $display("[TB] abort while idle");
    @(negedge clk); #1;
    abort = 1'b1;
    @(negedge clk); #1;
    abort = 1'b0;
    checkOutput("idle_abort_aborted", aborted, 0);
    checkOutput("idle_abort_busy", busy, 0);
    checkOutput("idle_abort_ready", cmd_ready, 1);

    $display("[TB] abort after and with a step completion");
    applyStimulus(10, 1'b1, 1'b0, base);
    runMove(10, 1'b1, 1, 5, base);
    applyStimulus(10, 1'b0, 1'b0, base);
    runMove(10, 1'b0, 2, 6, base);

    $display("[TB] command held while busy");
    applyStimulus(3, 1'b0, 1'b1, base);
    cmd_dir   = 1'b1;
    cmd_steps = 2;
    runMove(3, 1'b0, 0, 0, base);
    base = gen_q.size();
    @(posedge clk); #1;
    checkOutput("held_accept_busy", busy, 1);
    checkOutput("held_accept_dir", dir_out, 1);
    checkOutput("held_accept_steps_done", steps_done, 0);
    cmd_valid = 1'b0;
    runMove(2, 1'b1, 0, 0, base);

    $display("[TB] reset during acceleration");
    applyStimulus(10, 1'b1, 1'b0, base);
    waited = 0;
    while ((gen_q.size() - base) < 2 && waited < 2000) begin
      @(negedge clk); #1;
      waited++;
    end
    checkOutput("reset_mid_reached_accel", (gen_q.size() - base) >= 2, 1);
    rst = 1'b1;
    #1;
    checkResetValues("mid_reset");
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    stray_done = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #1;
      if (done || pg_start) stray_done = 1;
    end
    checkOutput("mid_reset_quiet", stray_done, 0);
    applyStimulus(4, 1'b1, 1'b0, base);
    runMove(4, 1'b1, 0, 0, base);

    $display("[TB] randomized moves");
    for (int t = 0; t < 12; t++) begin
      n    = $urandom_range(0, 16);
      dir  = 1'($urandom_range(0, 1));
      mode = (n >= 2) ? $urandom_range(0, 2) : 0;
      k    = (mode != 0) ? $urandom_range(1, n - 1) : 0;
      applyStimulus(n, dir, 1'b0, base);
      runMove(n, dir, mode, k, base);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
